// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS core (controller and datapath).
// Holds controller state codes, opcode constants, the next-PC select type and
// a helper that identifies the states that complete an instruction.
package mc_pkg;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_ADDR   = 4'd2;
    localparam logic [3:0] S_LW_MEM = 4'd3;
    localparam logic [3:0] S_WB     = 4'd4;
    localparam logic [3:0] S_SW_MEM = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_R_WB   = 4'd7;
    localparam logic [3:0] S_BEQ    = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        PC_KEEP,
        PC_INC,
        PC_BRANCH,
        PC_JUMP
    } pc_sel_e;

    // States whose successor fetch marks the end of an instruction.
    function automatic logic is_last_state(input logic [3:0] s);
        return (s == S_WB) || (s == S_SW_MEM) || (s == S_R_WB) ||
               (s == S_BEQ) || (s == S_JUMP);
    endfunction

endpackage

// File: rtl/mc_pc_next.sv
// Combinational next-PC mux.
// Ports:
//   i_sel      select: keep / pc+4 / branch target / jump target
//   i_pc       current program counter
//   i_btarget  registered branch target
//   i_jidx     ir[25:0] jump index
//   o_pc_next  selected next program counter
module mc_pc_next
    import mc_pkg::*;
(
    input  pc_sel_e     i_sel,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_btarget,
    input  logic [25:0] i_jidx,
    output logic [31:0] o_pc_next
);

    always_comb begin
        o_pc_next = i_pc;
        unique case (i_sel)
            PC_KEEP:   o_pc_next = i_pc;
            PC_INC:    o_pc_next = i_pc + 32'd4;
            PC_BRANCH: o_pc_next = i_btarget;
            PC_JUMP:   o_pc_next = {i_pc[31:28], i_jidx, 2'b00};
            default:   o_pc_next = i_pc;
        endcase
    end

endmodule

// File: rtl/mc_fetch_datapath.sv
// Architectural-register half of the multicycle MIPS core. Follows the
// controller state to sequence PC, IR and MDR, drives the memory port, counts
// retired instructions and flags a controller stuck in decode.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   i_state         controller state (0..9 used)
//   i_hold          freeze all registers and drop strobes
//   i_mem_rdata     memory read data
//   i_alu_result    ALU result (effective address in states 3/5)
//   i_alu_zero      ALU zero flag (branch decision in state 8)
//   o_pc, o_ir, o_mdr          architectural registers
//   o_opcode        ir[31:26]
//   o_mem_addr, o_mem_read, o_mem_write   memory port
//   o_retired_cnt   completed instructions, wrapping
//   o_illegal_op    sticky decode-stall flag
module mc_fetch_datapath
    import mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned STALL_LIMIT = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       i_state,
    input  logic             i_hold,
    input  logic [31:0]      i_mem_rdata,
    input  logic [31:0]      i_alu_result,
    input  logic             i_alu_zero,
    output logic [31:0]      o_pc,
    output logic [31:0]      o_ir,
    output logic [5:0]       o_opcode,
    output logic [31:0]      o_mdr,
    output logic [31:0]      o_mem_addr,
    output logic             o_mem_read,
    output logic             o_mem_write,
    output logic [CNT_W-1:0] o_retired_cnt,
    output logic             o_illegal_op
);

    localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);

    logic [31:0]      r_pc, r_ir, r_mdr, r_btarget;
    logic [3:0]       r_prev_state;
    logic [CNT_W-1:0] r_retired_cnt;
    logic [STALL_W-1:0] r_stall_cnt;
    logic             r_illegal_op;

    pc_sel_e          w_pc_sel;
    logic [31:0]      w_pc_next;
    logic [31:0]      w_br_off;
    logic [STALL_W-1:0] w_stall_next;
    logic             w_mem_state;

    // Next-PC selection; hold forces PC_KEEP so the mux output equals r_pc.
    always_comb begin
        w_pc_sel = PC_KEEP;
        if (!i_hold) begin
            if (i_state == S_FETCH) begin
                w_pc_sel = PC_INC;
            end else if (i_state == S_BEQ && i_alu_zero) begin
                w_pc_sel = PC_BRANCH;
            end else if (i_state == S_JUMP) begin
                w_pc_sel = PC_JUMP;
            end
        end
    end

    mc_pc_next u_pc_next (
        .i_sel     (w_pc_sel),
        .i_pc      (r_pc),
        .i_btarget (r_btarget),
        .i_jidx    (r_ir[25:0]),
        .o_pc_next (w_pc_next)
    );

    assign w_br_off = {{14{r_ir[15]}}, r_ir[15:0], 2'b00};

    // Run length of back-to-back decode cycles, saturating at the limit.
    always_comb begin
        w_stall_next = '0;
        if (i_state == S_DECODE) begin
            w_stall_next = r_stall_cnt;
            if (r_prev_state == S_DECODE && r_stall_cnt != STALL_W'(STALL_LIMIT)) begin
                w_stall_next = r_stall_cnt + STALL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_ir          <= '0;
            r_mdr         <= '0;
            r_btarget     <= '0;
            r_prev_state  <= '0;
            r_retired_cnt <= '0;
            r_stall_cnt   <= '0;
            r_illegal_op  <= 1'b0;
        end else if (!i_hold) begin
            r_pc         <= w_pc_next;
            r_prev_state <= i_state;
            r_stall_cnt  <= w_stall_next;
            if (w_stall_next == STALL_W'(STALL_LIMIT)) begin
                r_illegal_op <= 1'b1;
            end
            if (i_state == S_FETCH) begin
                r_ir <= i_mem_rdata;
                if (is_last_state(r_prev_state)) begin
                    r_retired_cnt <= r_retired_cnt + CNT_W'(1);
                end
            end
            // r_pc here is already pc+4 from the fetch cycle.
            if (i_state == S_DECODE) begin
                r_btarget <= r_pc + w_br_off;
            end
            if (i_state == S_LW_MEM) begin
                r_mdr <= i_mem_rdata;
            end
        end
    end

    assign w_mem_state   = (i_state == S_LW_MEM) || (i_state == S_SW_MEM);
    assign o_mem_addr    = w_mem_state ? i_alu_result : r_pc;
    assign o_mem_read    = !i_hold && ((i_state == S_FETCH) || (i_state == S_LW_MEM));
    assign o_mem_write   = !i_hold && (i_state == S_SW_MEM);

    assign o_pc          = r_pc;
    assign o_ir          = r_ir;
    assign o_opcode      = r_ir[31:26];
    assign o_mdr         = r_mdr;
    assign o_retired_cnt = r_retired_cnt;
    assign o_illegal_op  = r_illegal_op;

endmodule

// File: tb/tb_mc_fetch_datapath.sv
// Directed scenarios followed by randomized cycles, all checked against a
// cycle-level behavioural model of the architectural registers.
module tb_mc_fetch_datapath;

    localparam int STALL_LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  state;
    logic        hold;
    logic [31:0] mem_rdata, alu_result;
    logic        alu_zero;

    logic [31:0] pc, ir, mdr, mem_addr;
    logic [5:0]  opcode;
    logic        mem_read, mem_write, illegal_op;
    logic [15:0] retired_cnt;

    logic [31:0] hi_pc, hi_ir, hi_mdr, hi_mem_addr;
    logic [5:0]  hi_opcode;
    logic        hi_mem_read, hi_mem_write, hi_illegal_op;
    logic [15:0] hi_retired_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_ir, m_mdr, m_bt;
    int          m_ret, m_prev, m_run;
    bit          m_ill;

    always #5 clk = ~clk;

    mc_fetch_datapath u_dut (
        .clk           (clk),
        .reset         (reset),
        .i_state       (state),
        .i_hold        (hold),
        .i_mem_rdata   (mem_rdata),
        .i_alu_result  (alu_result),
        .i_alu_zero    (alu_zero),
        .o_pc          (pc),
        .o_ir          (ir),
        .o_opcode      (opcode),
        .o_mdr         (mdr),
        .o_mem_addr    (mem_addr),
        .o_mem_read    (mem_read),
        .o_mem_write   (mem_write),
        .o_retired_cnt (retired_cnt),
        .o_illegal_op  (illegal_op)
    );

    // Second instance with a high reset PC to exercise jump-region preservation.
    mc_fetch_datapath #(.RESET_PC(32'h4000_0004)) u_dut_hi (
        .clk           (clk),
        .reset         (reset),
        .i_state       (state),
        .i_hold        (hold),
        .i_mem_rdata   (mem_rdata),
        .i_alu_result  (alu_result),
        .i_alu_zero    (alu_zero),
        .o_pc          (hi_pc),
        .o_ir          (hi_ir),
        .o_opcode      (hi_opcode),
        .o_mdr         (hi_mdr),
        .o_mem_addr    (hi_mem_addr),
        .o_mem_read    (hi_mem_read),
        .o_mem_write   (hi_mem_write),
        .o_retired_cnt (hi_retired_cnt),
        .o_illegal_op  (hi_illegal_op)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_clk(input int st, input bit h, input logic [31:0] rd,
                             input bit z, input bit rst);
        logic [31:0] off;
        if (rst) begin
            m_pc = 32'h0; m_ir = 0; m_mdr = 0; m_bt = 0;
            m_ret = 0; m_prev = 0; m_run = 0; m_ill = 0;
        end else if (!h) begin
            if (st == 0 && (m_prev == 4 || m_prev == 5 || m_prev == 7 ||
                            m_prev == 8 || m_prev == 9))
                m_ret = (m_ret + 1) % 65536;
            if (st == 1) m_run++;
            else m_run = 0;
            if (m_run > STALL_LIMIT) m_ill = 1;
            case (st)
                0: begin m_ir = rd; m_pc = m_pc + 32'd4; end
                1: begin
                    off  = {{16{m_ir[15]}}, m_ir[15:0]};
                    m_bt = m_pc + off * 4;
                end
                3: m_mdr = rd;
                8: if (z) m_pc = m_bt;
                9: m_pc = (m_pc & 32'hF000_0000) | ((m_ir & 32'h03FF_FFFF) * 4);
                default: ;
            endcase
            m_prev = st;
        end
    endtask

    // One clock cycle: drive, check combinational outputs, clock, check registers.
    task automatic step(input int st, input bit h = 0, input logic [31:0] rd = 0,
                        input logic [31:0] alu = 0, input bit z = 0, input bit rst = 0);
        reset = rst; state = 4'(st); hold = h; mem_rdata = rd;
        alu_result = alu; alu_zero = z;
        #1;
        chk("mem_addr", mem_addr, (st == 3 || st == 5) ? alu : m_pc);
        chk("mem_read", 32'(mem_read), 32'(!h && (st == 0 || st == 3)));
        chk("mem_write", 32'(mem_write), 32'(!h && st == 5));
        chk("opcode", 32'(opcode), m_ir >> 26);
        @(posedge clk);
        model_clk(st, h, rd, z, rst);
        #1;
        chk("pc", pc, m_pc);
        chk("ir", ir, m_ir);
        chk("mdr", mdr, m_mdr);
        chk("retired_cnt", 32'(retired_cnt), 32'(m_ret));
        chk("illegal_op", 32'(illegal_op), 32'(m_ill));
    endtask

    initial begin
        m_pc = 0; m_ir = 0; m_mdr = 0; m_bt = 0;
        m_ret = 0; m_prev = 0; m_run = 0; m_ill = 0;

        // 1: reset and first fetch
        step(.st(0), .rst(1));
        chk("t1_reset_pc", pc, 32'h0);
        chk("t1_reset_ill", 32'(illegal_op), 32'h0);
        step(.st(0), .rd(32'h8C01_0004));
        chk("t1_ir", ir, 32'h8C01_0004);
        chk("t1_pc", pc, 32'h4);
        chk("t1_opcode", 32'(opcode), 32'h23);

        // 2: beq taken and not taken
        step(.st(0), .rst(1));
        step(.st(0), .rd(32'h1000_0003));
        step(.st(1));
        step(.st(8), .z(1));
        chk("t2_beq_taken", pc, 32'h10);
        step(.st(0), .rst(1));
        step(.st(0), .rd(32'h1000_0003));
        step(.st(1));
        step(.st(8), .z(0));
        chk("t2_beq_not_taken", pc, 32'h4);

        // 3: jump keeps pc[31:28]
        step(.st(0), .rst(1));
        chk("t3_hi_reset_pc", hi_pc, 32'h4000_0004);
        step(.st(0), .rd(32'h0800_0010));
        chk("t3_hi_pc_fetch", hi_pc, 32'h4000_0008);
        step(.st(1));
        step(.st(9));
        chk("t3_hi_jump", hi_pc, 32'h4000_0040);
        chk("t3_hi_ir", hi_ir, 32'h0800_0010);

        // 4: lw sequence, retire, pc wrap
        step(.st(0), .rst(1));
        step(.st(0), .rd(32'h8C01_0004));
        step(.st(1));
        step(.st(2), .alu(32'h20));
        step(.st(3), .alu(32'h20), .rd(32'hDEAD_BEEF));
        chk("t4_mdr", mdr, 32'hDEAD_BEEF);
        step(.st(4));
        chk("t4_ret_before", 32'(retired_cnt), 32'h0);
        step(.st(0), .rd(32'h0));
        chk("t4_ret_after", 32'(retired_cnt), 32'h1);
        step(.st(0), .rst(1));
        step(.st(0), .rd(32'h1000_FFFE));
        step(.st(1));
        step(.st(8), .z(1));
        chk("t4_pc_top", pc, 32'hFFFF_FFFC);
        step(.st(0), .rd(32'h0));
        chk("t4_pc_wrap", pc, 32'h0);

        // 5: decode stall detection
        step(.st(0), .rst(1));
        step(.st(0), .rd(32'h0));
        for (int i = 1; i <= 6; i++) begin
            step(.st(1));
            if (i == 4) chk("t5_ill_4th", 32'(illegal_op), 32'h0);
            if (i == 5) chk("t5_ill_5th", 32'(illegal_op), 32'h1);
        end
        step(.st(0), .rd(32'h0));
        chk("t5_ill_sticky", 32'(illegal_op), 32'h1);

        // 5b: same sequence frozen by hold
        step(.st(0), .rst(1));
        step(.st(0), .h(1), .rd(32'h1234_5678));
        for (int i = 0; i < 6; i++) step(.st(1), .h(1));
        step(.st(0), .h(1), .rd(32'h1234_5678));
        chk("t5_hold_ill", 32'(illegal_op), 32'h0);
        chk("t5_hold_pc", pc, 32'h0);
        chk("t5_hold_ir", ir, 32'h0);

        // 5c: reset mid store
        step(.st(0), .rd(32'hAC01_0008));
        step(.st(1));
        step(.st(2));
        step(.st(5), .alu(32'h40), .rst(1));
        chk("t5_rst_pc", pc, 32'h0);
        chk("t5_rst_ir", ir, 32'h0);
        chk("t5_rst_ret", 32'(retired_cnt), 32'h0);

        // Randomized cycles
        for (int i = 0; i < 500; i++) begin
            int st;
            st = ($urandom_range(0, 99) < 35) ? 1 : int'($urandom_range(0, 15));
            step(.st(st), .h($urandom_range(0, 99) < 20), .rd($urandom),
                 .alu($urandom), .z($urandom_range(0, 1) == 1),
                 .rst($urandom_range(0, 99) < 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
